// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Width of the watchdog counter; never narrower than one bit so the
  // register still exists when the watchdog is disabled.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin pick: first requester after last_gnt_i, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_gnt_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_req_o
);

  logic             found;
  logic [IDX_W:0]   cand_w;
  logic [IDX_W-1:0] cand;

  // Scan last_gnt_i+1 .. last_gnt_i+NUM_REQ modulo NUM_REQ; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_req_o = |req_i;
    found     = 1'b0;
    cand_w    = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_w = {1'b0, last_gnt_i} + (IDX_W+1)'(i);
      if (cand_w >= (IDX_W+1)'(NUM_REQ)) begin
        cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
      end
      cand = cand_w[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port among NUM_REQ requesters.
//
// state  | meaning
// IDLE   | no transfer on the bus; grant and latch a request if any is pending
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1 until pready or watchdog abort
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [APB_DATA_WIDTH-1:0]         rsp_rdata,
  output logic                              rsp_err,
  output logic [APB_ADDR_WIDTH-1:0]         paddr,
  output logic [APB_DATA_WIDTH-1:0]         pwdata,
  output logic                              pwrite,
  output logic                              psel,
  output logic                              penable,
  input  logic [APB_DATA_WIDTH-1:0]         prdata,
  input  logic                              pready,
  input  logic                              pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  // The counter is loaded in SETUP and reaches zero in ACCESS cycle TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TO_LOAD =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          last_gnt_q, last_gnt_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]        gnt;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      any_req;
  logic [APB_ADDR_WIDTH-1:0] sel_addr;
  logic [APB_DATA_WIDTH-1:0] sel_wdata;
  logic                      sel_write;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i      (req_valid),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .any_req_o  (any_req)
  );

  // Mux the granted requester's fields out of the flattened buses.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        sel_wdata = req_wdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  // Next-state, transfer latching and response capture.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready  = gnt;
          addr_d     = sel_addr;
          write_d    = sel_write;
          wdata_d    = sel_write ? sel_wdata : '0;
          last_gnt_d = gnt_idx;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = TO_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        // last_gnt_q doubles as the owner of the in-flight transfer.
        if (pready) begin
          rsp_valid_d[last_gnt_q] = 1'b1;
          rsp_err_d               = pslverr;
          rsp_rdata_d             = write_q ? '0 : prdata;
          cnt_d                   = '0;
          state_d                 = IDLE;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == '0)) begin
          rsp_valid_d[last_gnt_q] = 1'b1;
          rsp_err_d               = 1'b1;
          rsp_rdata_d             = '0;
          state_d                 = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      last_gnt_q  <= IDX_W'(NUM_REQ - 1);
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign pwrite    = write_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
